// File: rtl/top16_frame_pkg.sv
// Shared state encoding, constants and result type for the top-16 frame controller.
package top16_frame_pkg;

  localparam int TOP_N        = 16;
  localparam int TOP_SHIFT    = 4;
  localparam int DEF_W        = 12;
  localparam int DEF_CW       = 16;
  localparam int DEF_SORT_LAT = 2;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_W-1:0]  mean_v;
    logic [DEF_W-1:0]  max_v;
    logic [DEF_CW-1:0] cnt_v;
    logic              short_v;
  } frame_res_t;

  // A frame shorter than the sorter depth leaves zero padding in the top-16 set.
  function automatic logic is_short(input logic [31:0] cnt);
    return (cnt < 32'(TOP_N));
  endfunction

endpackage

// File: rtl/top16_frame_ctrl.sv
// Frame controller wrapping the top-16 max/sum sorter: clears it per frame, forwards
// samples, waits out sorter latency and emits one {mean, max, count, short} result word.
module top16_frame_ctrl
  import top16_frame_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int CW       = DEF_CW,
  parameter int SORT_LAT = DEF_SORT_LAT
) (
  input  logic          clk,
  input  logic          synrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          sort_clr,
  output logic          sort_en,
  output logic [W-1:0]  sort_data,
  input  logic [W-1:0]  sort_max,
  input  logic [W+3:0]  sort_sum,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_mean,
  output logic [W-1:0]  res_max,
  output logic [CW-1:0] res_cnt,
  output logic          res_short
);

  localparam int LCW = $clog2(SORT_LAT + 1);
  localparam logic [LCW-1:0] LAT_LAST = LCW'(SORT_LAT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  state_e          state_q, state_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CW-1:0]   smp_cnt_q, smp_cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            sort_clr_q, sort_clr_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_mean_q, res_mean_d;
  logic [W-1:0]    res_max_q, res_max_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic            res_short_q, res_short_d;
  logic            accept_s;
  logic            load_s;

  assign accept_s  = in_valid & in_ready_q;
  assign load_s    = (state_q == HOLD) & (~res_valid_q | res_ready);

  assign in_ready  = in_ready_q;
  assign sort_clr  = sort_clr_q;
  assign sort_en   = accept_s;
  assign sort_data = in_data;
  assign res_valid = res_valid_q;
  assign res_mean  = res_mean_q;
  assign res_max   = res_max_q;
  assign res_cnt   = res_cnt_q;
  assign res_short = res_short_q;

  // Next-state, counter and result-word logic.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    res_valid_d = res_valid_q;
    res_mean_d  = res_mean_q;
    res_max_d   = res_max_q;
    res_cnt_d   = res_cnt_q;
    res_short_d = res_short_q;

    case (state_q)
      CLEAR: begin
        smp_cnt_d = {CW{1'b0}};
        lat_cnt_d = {LCW{1'b0}};
        state_d   = RUN;
      end
      RUN: begin
        if (accept_s) begin
          if (smp_cnt_q != CNT_MAX) begin
            smp_cnt_d = smp_cnt_q + CW'(1);
          end else begin
            smp_cnt_d = smp_cnt_q;
          end
          if (in_last) begin
            state_d   = DRAIN;
            lat_cnt_d = {LCW{1'b0}};
          end else begin
            state_d   = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        lat_cnt_d = lat_cnt_q + LCW'(1);
        if (lat_cnt_q == LAT_LAST) begin
          state_d = HOLD;
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // Waiting here keeps the sorter frozen until the previous word is consumed.
        if (load_s) begin
          state_d = CLEAR;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (load_s) begin
      res_valid_d = 1'b1;
      res_mean_d  = W'(sort_sum >> TOP_SHIFT);
      res_max_d   = sort_max;
      res_cnt_d   = smp_cnt_q;
      res_short_d = is_short(32'(smp_cnt_q));
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    in_ready_d = (state_d == RUN);
    sort_clr_d = (state_d == CLEAR);
  end

  // State and registered outputs; reset re-enters CLEAR so the sorter is cleared again.
  always_ff @(posedge clk) begin
    if (synrst) begin
      state_q     <= CLEAR;
      lat_cnt_q   <= {LCW{1'b0}};
      smp_cnt_q   <= {CW{1'b0}};
      in_ready_q  <= 1'b0;
      sort_clr_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_mean_q  <= {W{1'b0}};
      res_max_q   <= {W{1'b0}};
      res_cnt_q   <= {CW{1'b0}};
      res_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      in_ready_q  <= in_ready_d;
      sort_clr_q  <= sort_clr_d;
      res_valid_q <= res_valid_d;
      res_mean_q  <= res_mean_d;
      res_max_q   <= res_max_d;
      res_cnt_q   <= res_cnt_d;
      res_short_q <= res_short_d;
    end
  end

endmodule

// File: tb/tb_top16_frame_ctrl.sv
// Bench for top16_frame_ctrl: behavioural top-16 sorter, directed vector table,
// hand-written corner sequences and random frames checked against a queue model.
module tb_top16_frame_ctrl;
  import top16_frame_pkg::*;

  localparam int W  = DEF_W;
  localparam int CW = DEF_CW;
  localparam int SL = DEF_SORT_LAT;

  logic          clk;
  logic          synrst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          sort_clr;
  logic          sort_en;
  logic [W-1:0]  sort_data;
  logic [W-1:0]  sort_max;
  logic [W+3:0]  sort_sum;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_mean;
  logic [W-1:0]  res_max;
  logic [CW-1:0] res_cnt;
  logic          res_short;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rr = 1'b0;

  frame_res_t got_q[$];
  frame_res_t exp_q[$];
  int         gcyc_q[$];

  top16_frame_ctrl #(.W(W), .CW(CW), .SORT_LAT(SL)) dut (
    .clk(clk), .synrst(synrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sort_clr(sort_clr), .sort_en(sort_en), .sort_data(sort_data),
    .sort_max(sort_max), .sort_sum(sort_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mean(res_mean), .res_max(res_max), .res_cnt(res_cnt), .res_short(res_short)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sorter: input register, then top-16 set update, then registered sum.
  logic [W-1:0] top_a [TOP_N];
  logic [W-1:0] sd_q;
  logic         sd_v;
  logic [W+3:0] ssum_q;
  int           mi_s;
  logic [W-1:0] mx_s;
  logic [W+3:0] sum_s;

  always_comb begin
    mi_s  = 0;
    mx_s  = '0;
    sum_s = '0;
    for (int i = 0; i < TOP_N; i++) begin
      if (top_a[i] < top_a[mi_s]) mi_s = i;
      if (top_a[i] > mx_s) mx_s = top_a[i];
      sum_s = sum_s + (W+4)'(top_a[i]);
    end
  end

  always @(posedge clk) begin
    if (sort_clr || synrst) begin
      for (int i = 0; i < TOP_N; i++) top_a[i] <= '0;
      sd_v   <= 1'b0;
      sd_q   <= '0;
      ssum_q <= '0;
    end else begin
      sd_v   <= sort_en;
      sd_q   <= sort_data;
      if (sd_v && (sd_q > top_a[mi_s])) top_a[mi_s] <= sd_q;
      ssum_q <= sum_s;
    end
  end

  assign sort_max = mx_s;
  assign sort_sum = ssum_q;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_res(input string tag, input frame_res_t g, input frame_res_t e);
    chk_eq({tag, "_mean"},  g.mean_v,  e.mean_v);
    chk_eq({tag, "_max"},   g.max_v,   e.max_v);
    chk_eq({tag, "_cnt"},   g.cnt_v,   e.cnt_v);
    chk_eq({tag, "_short"}, g.short_v, e.short_v);
  endtask

  function automatic frame_res_t cur_w();
    frame_res_t w;
    w.mean_v  = res_mean;
    w.max_v   = res_max;
    w.cnt_v   = res_cnt;
    w.short_v = res_short;
    return w;
  endfunction

  // Reference: sort the whole frame, sum the 16 largest (zero padded), divide by 16.
  function automatic frame_res_t model(input int v[$]);
    int s[$];
    int sum;
    frame_res_t r;
    s = v;
    s.rsort();
    sum = 0;
    for (int i = 0; i < TOP_N && i < s.size(); i++) sum += s[i];
    r.mean_v  = W'(sum / 16);
    r.max_v   = W'(s[0]);
    r.cnt_v   = (v.size() > 65535) ? 16'hFFFF : CW'(v.size());
    r.short_v = (v.size() < 16);
    return r;
  endfunction

  // Output monitor: collects taken words and checks stability under backpressure.
  frame_res_t prev_w;
  bit         prev_stall = 1'b0;
  always @(negedge clk) begin
    if (synrst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk_eq("hold_valid", res_valid, 1);
        chk_eq("hold_stable", longint'(cur_w()), longint'(prev_w));
      end
      if (res_valid && res_ready) begin
        got_q.push_back(cur_w());
        gcyc_q.push_back(cyc);
      end
      prev_stall <= res_valid && !res_ready;
      prev_w     <= cur_w();
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the last sample is taken.
  task automatic drive_frame(input int v[$], input bit mark_last, input int gap_pct,
                             output int last_cyc);
    bit acc;
    last_cyc = 0;
    for (int i = 0; i < v.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = W'(v[i]);
      in_last  = mark_last && (i == v.size() - 1);
      acc = 1'b0;
      for (int n = 0; n < 300 && !acc; n++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          last_cyc = cyc;
        end
      end
      chk_eq("accept", acc, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 400 && got_q.size() < n; k++) @(negedge clk);
    chk_eq("result_count", got_q.size(), n);
  endtask

  task automatic check_scoreboard(input string tag);
    frame_res_t g;
    frame_res_t e;
    int idx;
    wait_got(exp_q.size());
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(gcyc_q.pop_front());
      cmp_res($sformatf("%s%0d", tag, idx), g, e);
      idx++;
    end
    got_q.delete();
    gcyc_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int         len;
    int         base;
    int         step;
    frame_res_t exp;
  } vec_t;

  localparam int NV = 8;
  vec_t tab[NV];

  task automatic set_vec(input int k, input int len, input int base, input int step,
                         input int mean, input int mx, input int cnt, input bit sh);
    tab[k].len          = len;
    tab[k].base         = base;
    tab[k].step         = step;
    tab[k].exp.mean_v   = W'(mean);
    tab[k].exp.max_v    = W'(mx);
    tab[k].exp.cnt_v    = CW'(cnt);
    tab[k].exp.short_v  = sh;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  int         vals[$];
  int         lc;
  int         gc;
  int         vcnt;
  bit         found;
  frame_res_t g;
  frame_res_t e;

  initial begin
    synrst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b1;

    fork
      forever begin
        @(posedge clk); #1;
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
      end
    join_none

    set_vec(0, 20, 1,    1,  12,   20,   20, 1'b0);
    set_vec(1, 2,  7,    -4, 0,    7,    2,  1'b1);
    set_vec(2, 16, 4095, 0,  4095, 4095, 16, 1'b0);
    set_vec(3, 1,  100,  0,  6,    100,  1,  1'b1);
    set_vec(4, 17, 1,    1,  9,    17,   17, 1'b0);
    set_vec(5, 15, 10,   0,  9,    10,   15, 1'b1);
    set_vec(6, 16, 16,   -1, 8,    16,   16, 1'b0);
    set_vec(7, 20, 40,   -2, 25,   40,   20, 1'b0);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_res_valid", res_valid, 0);
    chk_eq("rst_in_ready",  in_ready,  0);
    chk_eq("rst_sort_clr",  sort_clr,  1);
    chk_eq("rst_res_mean",  res_mean,  0);
    chk_eq("rst_res_max",   res_max,   0);
    chk_eq("rst_res_cnt",   res_cnt,   0);
    chk_eq("rst_res_short", res_short, 0);
    @(posedge clk); #1;
    synrst = 1'b0;
    @(negedge clk);
    chk_eq("clear_sort_clr", sort_clr, 1);
    chk_eq("clear_in_ready", in_ready, 0);
    @(negedge clk);
    chk_eq("run_sort_clr", sort_clr, 0);
    chk_eq("run_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vector table with latency check (res_ready held high).
    for (int k = 0; k < NV; k++) begin
      vals.delete();
      for (int i = 0; i < tab[k].len; i++) vals.push_back(tab[k].base + i * tab[k].step);
      drive_frame(vals, 1'b1, 0, lc);
      wait_got(1);
      if (got_q.size() > 0) begin
        g  = got_q.pop_front();
        gc = gcyc_q.pop_front();
        cmp_res($sformatf("vec%0d", k), g, tab[k].exp);
        chk_eq($sformatf("vec%0d_latency", k), gc - lc, SL + 2);
      end
      @(posedge clk); #1;
    end

    // T2: sorter clear pulses for one cycle together with the result, then RUN.
    vals = '{7, 3};
    drive_frame(vals, 1'b1, 0, lc);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (res_valid) found = 1'b1;
      else chk_eq("t2_clr_low", sort_clr, 0);
    end
    chk_eq("t2_result_seen", found, 1);
    chk_eq("t2_clr_pulse", sort_clr, 1);
    chk_eq("t2_ready_in_clear", in_ready, 0);
    @(negedge clk);
    chk_eq("t2_clr_drop", sort_clr, 0);
    chk_eq("t2_ready_rise", in_ready, 1);
    exp_q.push_back(model(vals));
    check_scoreboard("t2_");
    @(posedge clk); #1;

    // T3: backpressure on the first result stalls the second frame in HOLD.
    res_ready = 1'b0;
    vals = '{5, 9, 1};
    exp_q.push_back(model(vals));
    drive_frame(vals, 1'b1, 0, lc);
    vals = '{200, 17};
    exp_q.push_back(model(vals));
    drive_frame(vals, 1'b1, 0, lc);
    vals = '{33, 44, 55, 66};
    in_valid = 1'b1; in_data = W'(vals[0]); in_last = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk_eq("t3_ready_low", in_ready, 0);
      chk_eq("t3_valid",     res_valid, 1);
      chk_eq("t3_first_max", res_max, 9);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    exp_q.push_back(model(vals));
    drive_frame(vals, 1'b1, 0, lc);
    check_scoreboard("t3_");
    @(posedge clk); #1;

    // T5: reset mid-frame with a pending result; nothing may be emitted afterwards.
    res_ready = 1'b0;
    vals = '{1, 2};
    drive_frame(vals, 1'b1, 0, lc);
    vals = '{11, 12, 13, 14, 15};
    drive_frame(vals, 1'b0, 0, lc);
    @(negedge clk);
    chk_eq("t5_pending", res_valid, 1);
    @(posedge clk); #1;
    synrst = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    synrst = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    chk_eq("t5_no_result", vcnt, 0);
    chk_eq("t5_none_taken", got_q.size(), 0);
    got_q.delete();
    gcyc_q.delete();
    @(posedge clk); #1;
    vals = '{100};
    e.mean_v = 12'd6; e.max_v = 12'd100; e.cnt_v = 16'd1; e.short_v = 1'b1;
    exp_q.push_back(e);
    drive_frame(vals, 1'b1, 0, lc);
    check_scoreboard("t5_");
    @(posedge clk); #1;

    // T6: random frames, input gaps and random consumer backpressure.
    rand_rr = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int len;
      int mode;
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      vals.delete();
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       vals.push_back($urandom_range(0, 4095));
          1:       vals.push_back($urandom_range(0, 15));
          default: vals.push_back($urandom_range(4000, 4095));
        endcase
      end
      exp_q.push_back(model(vals));
      drive_frame(vals, 1'b1, 30, lc);
    end
    rand_rr = 1'b0;
    @(posedge clk); #2;
    res_ready = 1'b1;
    check_scoreboard("t6_");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
